ps2_rx: RTL
===========

# ps2_rx

Receive-side PS/2 deserializer for the mouse/keyboard port of the microprocessor system. It synchronizes and glitch-filters the open-collector PS/2 clock and data lines, captures 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop) and presents each byte with a one-cycle valid strobe. Its outputs feed the peripheral bus and the seven-segment debug display in the top level.

## Interface
- FILTER_LEN, 8: consecutive CLK100_IN cycles the synchronized ps2_clk must hold a new level before the filtered clock follows it; legal range 2..255.
- TIMEOUT_CYC, 200000: cycles without a filtered falling edge, while a frame is in progress, before the frame is aborted (2 ms at 100 MHz); SIMULATION builds use 500; width 18 bits.
- CLK100_IN  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to CLK100_IN.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- rx_en  input  1  receive enable; low while the host transmitter owns the bus.
- byte_data  output  8  last received byte; holds until the next good frame.
- byte_valid  output  1  one-cycle pulse, byte_data updated and parity good.
- parity_err  output  1  one-cycle pulse, frame complete but parity wrong.
- frame_err  output  1  one-cycle pulse, bad stop bit or timeout.
- busy  output  1  high from accepted start bit until the frame completes or aborts.

## Operation
- Input conditioning: ps2_clk and ps2_data each pass a 2-flop synchronizer (reset value 1). Filtered clock clk_f (reset 1) takes the synchronized level once it differs from clk_f for FILTER_LEN consecutive cycles; any bounce restarts the count. fall strobe = clk_f transition 1->0, one cycle wide. Data bit sampled = synchronized ps2_data in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fall with rx_en=1 and data=0 -> DATA, bit counter=0, shift register cleared. fall with data=1 (false start) or rx_en=0: stay IDLE, no flags.
- DATA: on each fall, shift bit in at MSB (right shift, LSB first on wire); after 8th bit -> PARITY.
- PARITY: on fall capture parity bit -> STOP.
- STOP: on fall: stop=1 and XOR(8 data bits, parity)=1 -> byte_data <= shifted byte, byte_valid pulse; stop=1 and XOR=0 -> parity_err pulse, byte_data unchanged; stop=0 -> frame_err pulse only (stop error takes precedence over parity). Always -> IDLE.
- Timeout: idle counter clears on every fall and in IDLE; reaching TIMEOUT_CYC in DATA/PARITY/STOP -> frame_err pulse, -> IDLE, partial byte discarded.
- rx_en falling mid-frame: abort to IDLE next cycle, no flags.
- busy = (state != IDLE).
- Reset (any time, including mid-frame): state IDLE, byte_data 0x00, byte_valid 0, parity_err 0, frame_err 0, busy 0, counters 0, synchronizers and clk_f 1.

## Timing
- Pin falling edge to fall strobe: 2 sync cycles + FILTER_LEN cycles (10 cycles at default), fixed for a clean edge.
- byte_valid / parity_err / frame_err asserted the cycle after the stop-bit fall strobe, exactly one cycle; never two flags in the same cycle.
- Timeout flag asserted the cycle after the counter hits TIMEOUT_CYC.
- Back-to-back frames: a start-bit fall arriving the cycle after STOP completes is accepted (FSM in IDLE by then).
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fall strobe.
- Minimum supported PS/2 half-period: FILTER_LEN+4 cycles; real devices (30-50 µs) are far above this.

## Test plan
- Clean frame 0xFA, odd parity bit 1, stop 1, 12.5 kHz PS/2 clock -> one byte_valid pulse, byte_data=0xFA, busy low afterwards, no error flags.
- Frame 0x00 with parity bit 0 -> parity_err single pulse, byte_data retains previous 0xFA, byte_valid never asserted.
- Frame 0xAA, stop bit driven 0 -> frame_err pulse, no byte_valid, no parity_err.
- Stop clocking after 4 data bits (SIMULATION, TIMEOUT_CYC=500) -> frame_err 501 cycles after last fall, busy drops; following clean frame 0x08 received correctly.
- 3-cycle low glitches on ps2_clk during idle and between bits, plus data=1 at first fall -> no fall accepted as start, no flags; subsequent frame 0x55 received as 0x55.
- Assert rst_n low mid-frame after 5 bits, release, send 0x14 -> all outputs reset to 0 during reset, then byte_valid with byte_data=0x14.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver pin and byte-output bundle.
// The receiver uses the slave view; the driving environment uses the master view.
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rx_en;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  ps2_clk, ps2_data, rx_en,
        output byte_data, byte_valid, parity_err, frame_err, busy
    );

    modport master (
        output ps2_clk, ps2_data, rx_en,
        input  byte_data, byte_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the pins, then
// deserializes 11-bit frames into bytes with parity, stop-bit and timeout checks.
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic     CLK100_IN,
    input  logic     rst_n,
    ps2_rx_if.slave  bus
);
    localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [17:0] TO_MAX   = 18'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]  clk_sync_q, dat_sync_q;
    logic        clk_f_q, fall_q;
    logic [7:0]  flt_cnt_q;
    logic [17:0] to_cnt_q;
    logic        dat_s;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        par_q, par_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;

    assign dat_s = dat_sync_q[1];

    // Clock filter: clk_f follows the synchronized pin only after it has held
    // the new level for FILTER_LEN consecutive cycles; fall_q marks 1->0.
    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_f_q    <= 1'b1;
            fall_q     <= 1'b0;
            flt_cnt_q  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
            fall_q     <= 1'b0;
            if (clk_sync_q[1] != clk_f_q) begin
                if (flt_cnt_q == FILT_MAX) begin
                    clk_f_q   <= clk_sync_q[1];
                    fall_q    <= clk_f_q;
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 8'd1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (state_q == IDLE || fall_q)
                to_cnt_q <= '0;
            else if (to_cnt_q != TO_MAX)
                to_cnt_q <= to_cnt_q + 18'd1;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q == IDLE) begin
            if (fall_q && bus.rx_en && !dat_s) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                shift_d   = '0;
            end
        end else if (!bus.rx_en) begin
            state_d = IDLE;
        end else if (to_cnt_q == TO_MAX) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
        end else if (fall_q) begin
            case (state_q)
                DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
                default: begin
                    // A bad stop bit outranks a parity error.
                    if (!dat_s) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.byte_data  = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
